// File: rtl/int_pending_ctrl.sv
// int_pending_ctrl: captures device completion edges into pending bits and grants
// one source at a time to vectored_int. Define INT_MASK_EN for the mask register.
module int_pending_ctrl #(
    parameter int NUM_SRC     = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] dev_done,
    input  logic               int_ack,
    input  logic               eoi,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_wd,
    output logic               int_req,
    output logic [NUM_SRC-1:0] done_out,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] overrun
);
    localparam int GW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_q;
    logic [NUM_SRC-1:0] prev_q;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] ovr_q, ovr_d;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] elig;
    logic [NUM_SRC-1:0] grant_oh;
    logic [NUM_SRC-1:0] clr;
    logic [GW-1:0]      grant_q, grant_d, pick;

    // prev_q resets low, so a level already high at release reads as an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= dev_done;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

`ifdef INT_MASK_EN
    logic [NUM_SRC-1:0] mask_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '0;
        end else if (mask_we) begin
            mask_q <= mask_wd;
        end
    end

    assign mask = mask_q;
`else
    logic unused_mask;

    assign unused_mask = ^{mask_we, mask_wd};
    assign mask        = '0;
`endif

    assign elig     = pend_q & ~mask;
    assign grant_oh = {{(NUM_SRC-1){1'b0}}, 1'b1} << grant_q;

    // ascending scan: the last eligible index seen is the highest
    always_comb begin
        pick = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (elig[i]) begin
                pick = GW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (|elig) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (|(mask & grant_oh)) begin
                    state_d = IDLE;
                end else if (int_ack) begin
                    state_d = SERVICE;
                end
            end
            SERVICE: begin
                if (eoi) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        int_req  = 1'b0;
        done_out = '0;
        unique case (state_q)
            REQ: begin
                int_req  = 1'b1;
                done_out = grant_oh;
            end
            SERVICE: done_out = grant_oh;
            default: ;
        endcase
    end

    assign grant_d = (state_q == IDLE && |elig) ? pick : grant_q;
    assign clr     = (state_q == SERVICE && eoi) ? grant_oh : '0;

    // a fresh edge on the cleared source re-sets pending but not overrun
    assign pend_d = (pend_q & ~clr) | rise;
    assign ovr_d  = (ovr_q | (rise & pend_q)) & ~clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q <= '0;
            pend_q  <= '0;
            ovr_q   <= '0;
        end else begin
            grant_q <= grant_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
        end
    end

    assign pending = pend_q;
    assign overrun = ovr_q;

endmodule

// File: tb/tb_int_pending_ctrl.sv
// Bench for int_pending_ctrl: directed scenarios plus randomized traffic
// checked against a behavioural model of pending/grant/service rules.
`timescale 1ns/1ps
module tb_int_pending_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] dev_done = '0;
    logic       int_ack = 1'b0;
    logic       eoi = 1'b0;
    logic       mask_we = 1'b0;
    logic [3:0] mask_wd = '0;
    logic       int_req;
    logic [3:0] done_out;
    logic [3:0] pending;
    logic [3:0] overrun;

    int n_tests = 0;
    int n_fail = 0;

    int_pending_ctrl #(.NUM_SRC(4), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .dev_done(dev_done),
        .int_ack(int_ack), .eoi(eoi), .mask_we(mask_we),
        .mask_wd(mask_wd), .int_req(int_req), .done_out(done_out),
        .pending(pending), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // model: level history (most recent first), phase 0=idle 1=asking 2=serving
    logic [3:0] hist [4];
    logic [3:0] m_pend, m_ovr, m_mask;
    int m_ph, m_g;

    function automatic logic m_req();
        return m_ph == 1;
    endfunction

    function automatic logic [3:0] m_done();
        logic [3:0] one;
        one = 4'b0001;
        return (m_ph != 0) ? (one << m_g) : 4'b0000;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) hist[i] = '0;
        m_pend = '0; m_ovr = '0; m_mask = '0;
        m_ph = 0; m_g = 0;
    endtask

    // a level rising at sample k shows up as pending at sample k+2
    task automatic model_step();
        logic [3:0] ev, elig, np, no;
        int og;
        for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = dev_done;
        ev = hist[2] & ~hist[3];
        elig = m_pend & ~m_mask;
        og = m_g;
        np = m_pend | ev;
        no = m_ovr | (ev & m_pend);
        if (m_ph == 2 && eoi) begin
            np[og] = ev[og];
            no[og] = 1'b0;
        end
        case (m_ph)
            0: if (elig != 0) begin
                for (int i = 3; i >= 0; i--)
                    if (elig[i]) begin m_g = i; break; end
                m_ph = 1;
            end
            1: if (m_mask[og]) m_ph = 0; else if (int_ack) m_ph = 2;
            default: if (eoi) m_ph = 0;
        endcase
        m_pend = np;
        m_ovr = no;
`ifdef INT_MASK_EN
        if (mask_we) m_mask = mask_wd;
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        dev_done = '0; int_ack = 0; eoi = 0; mask_we = 0; mask_wd = '0;
        model_reset();
        #3;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        dev_done = 4'b1111;
        #2;
        n_tests++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL rst_int_req got %b exp 0", int_req); end
        n_tests++; if (done_out !== 4'b0000) begin n_fail++; $display("FAIL rst_done got %b exp 0000", done_out); end
        n_tests++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL rst_pending got %b exp 0000", pending); end
        n_tests++; if (overrun !== 4'b0000) begin n_fail++; $display("FAIL rst_overrun got %b exp 0000", overrun); end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        dev_done = 4'b0001; tick();
        dev_done = 4'b0000; tick(); tick();
        n_tests++; if (pending !== 4'b0001) begin n_fail++; $display("FAIL single_pend got %b exp 0001", pending); end
        n_tests++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL single_req_early got %b exp 0", int_req); end
        tick();
        n_tests++; if (int_req !== 1'b1) begin n_fail++; $display("FAIL single_req got %b exp 1", int_req); end
        n_tests++; if (done_out !== 4'b0001) begin n_fail++; $display("FAIL single_done got %b exp 0001", done_out); end
        int_ack = 1; tick(); int_ack = 0;
        n_tests++; if (int_req !== 1'b0) begin n_fail++; $display("FAIL single_ack_req got %b exp 0", int_req); end
        n_tests++; if (done_out !== 4'b0001) begin n_fail++; $display("FAIL single_svc_done got %b exp 0001", done_out); end
        eoi = 1; tick(); eoi = 0;
        n_tests++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL single_eoi_pend got %b exp 0000", pending); end
        n_tests++; if (done_out !== 4'b0000) begin n_fail++; $display("FAIL single_eoi_done got %b exp 0000", done_out); end
    endtask

    task automatic test_two_sources();
        do_reset();
        dev_done = 4'b1010;
        repeat (4) tick();
        n_tests++; if (done_out !== 4'b1000) begin n_fail++; $display("FAIL two_first got %b exp 1000", done_out); end
        int_ack = 1; tick(); int_ack = 0;
        eoi = 1; tick(); eoi = 0;
        n_tests++; if (done_out !== 4'b0000 || int_req !== 1'b0) begin n_fail++; $display("FAIL two_gap got %b/%b exp 0000/0", done_out, int_req); end
        n_tests++; if (pending !== 4'b0010) begin n_fail++; $display("FAIL two_pend got %b exp 0010", pending); end
        tick();
        n_tests++; if (done_out !== 4'b0010 || int_req !== 1'b1) begin n_fail++; $display("FAIL two_second got %b/%b exp 0010/1", done_out, int_req); end
        int_ack = 1; tick(); int_ack = 0;
        eoi = 1; tick(); eoi = 0;
        dev_done = 4'b0000;
    endtask

    task automatic test_no_preempt();
        do_reset();
        dev_done = 4'b0010;
        repeat (4) tick();
        dev_done = 4'b1010;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_tests++; if (done_out !== 4'b0010) begin n_fail++; $display("FAIL nopre_hold%0d got %b exp 0010", i, done_out); end
        end
        n_tests++; if (pending !== 4'b1010) begin n_fail++; $display("FAIL nopre_pend got %b exp 1010", pending); end
        int_ack = 1; tick(); int_ack = 0;
        n_tests++; if (done_out !== 4'b0010) begin n_fail++; $display("FAIL nopre_svc got %b exp 0010", done_out); end
        eoi = 1; tick(); eoi = 0;
        tick();
        n_tests++; if (done_out !== 4'b1000) begin n_fail++; $display("FAIL nopre_next got %b exp 1000", done_out); end
        dev_done = 4'b0000;
    endtask

    task automatic test_overrun();
        do_reset();
        dev_done = 4'b0100; tick(); dev_done = 0; tick(); tick();
        tick();
        int_ack = 1; tick(); int_ack = 0;
        dev_done = 4'b0100; tick(); dev_done = 0; tick(); tick();
        n_tests++; if (overrun !== 4'b0100) begin n_fail++; $display("FAIL ovr_set got %b exp 0100", overrun); end
        dev_done = 4'b0100; tick(); dev_done = 0; tick();
        eoi = 1; tick(); eoi = 0;
        n_tests++; if (pending[2] !== 1'b1) begin n_fail++; $display("FAIL ovr_eoi_pend got %b exp 1", pending[2]); end
        n_tests++; if (overrun[2] !== 1'b0) begin n_fail++; $display("FAIL ovr_eoi_ovr got %b exp 0", overrun[2]); end
        n_tests++; if (done_out !== 4'b0000) begin n_fail++; $display("FAIL ovr_eoi_done got %b exp 0000", done_out); end
        tick();
        n_tests++; if (done_out !== 4'b0100) begin n_fail++; $display("FAIL ovr_regrant got %b exp 0100", done_out); end
    endtask

    task automatic test_all_four();
        logic [3:0] e, one;
        one = 4'b0001;
        do_reset();
        dev_done = 4'b1111;
        repeat (4) tick();
        eoi = 1; tick(); eoi = 0;
        n_tests++; if (int_req !== 1'b1 || pending !== 4'b1111) begin n_fail++; $display("FAIL all_eoi_req got %b/%b exp 1/1111", int_req, pending); end
        for (int k = 3; k >= 0; k--) begin
            e = one << k;
            n_tests++; if (done_out !== e || int_req !== 1'b1) begin n_fail++; $display("FAIL all_grant%0d got %b/%b exp %b/1", k, done_out, int_req, e); end
            if (k == 2) begin
                int_ack = 1; eoi = 1; tick(); int_ack = 0; eoi = 0;
                n_tests++; if (int_req !== 1'b0 || pending[2] !== 1'b1) begin n_fail++; $display("FAIL all_ackeoi got %b/%b exp 0/1", int_req, pending[2]); end
            end else begin
                int_ack = 1; tick(); int_ack = 0;
            end
            eoi = 1; tick(); eoi = 0;
            n_tests++; if (pending !== (e - 4'b0001)) begin n_fail++; $display("FAIL all_pend%0d got %b exp %b", k, pending, e - 4'b0001); end
            if (k > 0) tick();
        end
        dev_done = 4'b0000;
    endtask

    task automatic test_reset_mid();
        do_reset();
        dev_done = 4'b1011;
        repeat (4) tick();
        int_ack = 1; tick(); int_ack = 0;
        n_tests++; if (pending !== 4'b1011 || done_out !== 4'b1000) begin n_fail++; $display("FAIL mid_pre got %b/%b exp 1011/1000", pending, done_out); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if ({int_req, done_out, pending, overrun} !== 13'd0) begin n_fail++; $display("FAIL mid_async got %b exp 0", {int_req, done_out, pending, overrun}); end
        model_reset();
        dev_done = 4'b0000;
        @(negedge clk); rst_n = 1'b1;
        tick(); tick();
        n_tests++; if ({int_req, done_out, pending} !== 9'd0) begin n_fail++; $display("FAIL mid_after got %b exp 0", {int_req, done_out, pending}); end
    endtask

`ifdef INT_MASK_EN
    task automatic test_mask();
        do_reset();
        mask_we = 1; mask_wd = 4'b1000; tick(); mask_we = 0;
        dev_done = 4'b1001;
        repeat (4) tick();
        n_tests++; if (done_out !== 4'b0001 || int_req !== 1'b1) begin n_fail++; $display("FAIL mask_grant got %b/%b exp 0001/1", done_out, int_req); end
        mask_we = 1; mask_wd = 4'b1001; tick(); mask_we = 0;
        n_tests++; if (int_req !== m_req()) begin n_fail++; $display("FAIL mask_wr_req got %b exp %b", int_req, m_req()); end
        tick();
        n_tests++; if (int_req !== 1'b0 || pending !== 4'b1001) begin n_fail++; $display("FAIL mask_drop got %b/%b exp 0/1001", int_req, pending); end
        mask_we = 1; mask_wd = 4'b1111; tick(); mask_we = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++; if (int_req !== 1'b0 || pending !== 4'b1001) begin n_fail++; $display("FAIL mask_all%0d got %b/%b exp 0/1001", i, int_req, pending); end
        end
        dev_done = 4'b0000;
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(3) == 0) dev_done[b] = ~dev_done[b];
            int_ack = ($urandom_range(2) == 0);
            eoi = !eoi && ($urandom_range(2) == 0);
            mask_we = ($urandom_range(15) == 0);
            mask_wd = 4'($urandom);
            tick();
            n_tests++; if (int_req !== m_req()) begin n_fail++; $display("FAIL rnd_req c=%0d got %b exp %b", c, int_req, m_req()); end
            n_tests++; if (done_out !== m_done()) begin n_fail++; $display("FAIL rnd_done c=%0d got %b exp %b", c, done_out, m_done()); end
            n_tests++; if (pending !== m_pend) begin n_fail++; $display("FAIL rnd_pend c=%0d got %b exp %b", c, pending, m_pend); end
            n_tests++; if (overrun !== m_ovr) begin n_fail++; $display("FAIL rnd_ovr c=%0d got %b exp %b", c, overrun, m_ovr); end
        end
        int_ack = 0; eoi = 0; mask_we = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_two_sources();
        test_no_preempt();
        test_overrun();
        test_all_four();
        test_reset_mid();
`ifdef INT_MASK_EN
        test_mask();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
